// File: rtl/greenhouse_clock.sv
// greenhouse_clock
//
// Keeps the time of day (hh:mm:ss, 24 h) and a sunrise setting (hh:mm). It
// drives lights_on for the grow-light driver. It sits behind the front-panel
// menu stage and consumes that stage's adjust step codes.
//
// Parameters:
//   CLK_HZ        clock cycles per second (prescaler terminal count CLK_HZ-1)
//   LIGHT_MINUTES photoperiod length in minutes, 1..1439
//   REPEAT_CYCLES auto-repeat interval in cycles (auto-repeat build only)
//
// Ports:
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   time_adjust[2:0]     0 none, 1 min up, 2 min down, 3 hour up, 4 hour down,
//                        5-7 ignored
//   sunrise_time_adjust  same encoding, applied to the sunrise setting
//   hours/minutes/seconds          current time (registered)
//   sunrise_hours/sunrise_minutes  sunrise setting (registered)
//   lights_on            high while current time is inside the photoperiod
//   sec_tick             one-cycle pulse at each prescaler wrap
//
// Build option:
//   GH_CLOCK_AUTOREPEAT_EN  when defined, a held adjust code in 1-4 issues one
//                           extra step every REPEAT_CYCLES cycles after the
//                           first one.

module greenhouse_clock #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned LIGHT_MINUTES = 720,
  parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] time_adjust,
  input  logic [2:0] sunrise_time_adjust,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [4:0] sunrise_hours,
  output logic [5:0] sunrise_minutes,
  output logic       lights_on,
  output logic       sec_tick
);

  localparam int unsigned PrescW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PrescW-1:0] PrescTop = PrescW'(CLK_HZ - 1);

  localparam logic [2:0] AdjMinUp   = 3'd1;
  localparam logic [2:0] AdjMinDown = 3'd2;
  localparam logic [2:0] AdjHourUp  = 3'd3;
  localparam logic [2:0] AdjHourDn  = 3'd4;

  function automatic logic is_step_code(input logic [2:0] c);
    return (c >= AdjMinUp) && (c <= AdjHourDn);
  endfunction

  function automatic logic [5:0] wrap_up(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_down(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // State
  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [4:0]        hr_q, hr_d;
  logic [5:0]        min_q, min_d;
  logic [5:0]        sec_q, sec_d;
  logic [4:0]        sr_hr_q, sr_hr_d;
  logic [5:0]        sr_min_q, sr_min_d;
  logic              lights_q, lights_d;
  logic [2:0]        time_code_q, sr_code_q;

  // A step fires on a change into 1-4 relative to last cycle's code.
  logic time_edge, sr_edge;
  logic time_step, sr_step;

  assign time_edge = is_step_code(time_adjust) && (time_adjust != time_code_q);
  assign sr_edge   = is_step_code(sunrise_time_adjust) && (sunrise_time_adjust != sr_code_q);

`ifdef GH_CLOCK_AUTOREPEAT_EN
  localparam int unsigned HoldW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldTop = HoldW'(REPEAT_CYCLES);

  // Hold counters count cycles since the last issued step for a held code.
  logic [HoldW-1:0] time_hold_q, time_hold_d;
  logic [HoldW-1:0] sr_hold_q, sr_hold_d;
  logic             time_rep, sr_rep;

  always_comb begin
    time_hold_d = '0;
    time_rep    = 1'b0;
    if (is_step_code(time_adjust)) begin
      if (time_edge) begin
        time_hold_d = HoldW'(1);
      end else if (time_hold_q == HoldTop) begin
        time_rep    = 1'b1;
        time_hold_d = HoldW'(1);
      end else begin
        time_hold_d = time_hold_q + HoldW'(1);
      end
    end
  end

  always_comb begin
    sr_hold_d = '0;
    sr_rep    = 1'b0;
    if (is_step_code(sunrise_time_adjust)) begin
      if (sr_edge) begin
        sr_hold_d = HoldW'(1);
      end else if (sr_hold_q == HoldTop) begin
        sr_rep    = 1'b1;
        sr_hold_d = HoldW'(1);
      end else begin
        sr_hold_d = sr_hold_q + HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_hold_q <= '0;
      sr_hold_q   <= '0;
    end else begin
      time_hold_q <= time_hold_d;
      sr_hold_q   <= sr_hold_d;
    end
  end

  assign time_step = time_edge | time_rep;
  assign sr_step   = sr_edge | sr_rep;
`else
  assign time_step = time_edge;
  assign sr_step   = sr_edge;
`endif

  // Prescaler and time of day. A time step takes priority over the tick's
  // seconds increment; the tick pulse itself is never suppressed.
  logic tick;
  assign tick = (presc_q == PrescTop);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PrescW'(1);
    tick_d  = tick;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (time_step) begin
      case (time_adjust)
        AdjMinUp: begin
          min_d   = wrap_up(min_q, 6'd59);
          sec_d   = '0;
          presc_d = '0;
        end
        AdjMinDown: begin
          min_d   = wrap_down(min_q, 6'd59);
          sec_d   = '0;
          presc_d = '0;
        end
        AdjHourUp: hr_d = 5'(wrap_up({1'b0, hr_q}, 6'd23));
        AdjHourDn: hr_d = 5'(wrap_down({1'b0, hr_q}, 6'd23));
        default: ;
      endcase
    end else if (tick) begin
      sec_d = wrap_up(sec_q, 6'd59);
      if (sec_q == 6'd59) begin
        min_d = wrap_up(min_q, 6'd59);
        if (min_q == 6'd59) begin
          hr_d = 5'(wrap_up({1'b0, hr_q}, 6'd23));
        end
      end
    end
  end

  // Sunrise setting, independent of ticks and time steps.
  always_comb begin
    sr_hr_d  = sr_hr_q;
    sr_min_d = sr_min_q;
    if (sr_step) begin
      case (sunrise_time_adjust)
        AdjMinUp:   sr_min_d = wrap_up(sr_min_q, 6'd59);
        AdjMinDown: sr_min_d = wrap_down(sr_min_q, 6'd59);
        AdjHourUp:  sr_hr_d  = 5'(wrap_up({1'b0, sr_hr_q}, 6'd23));
        AdjHourDn:  sr_hr_d  = 5'(wrap_down({1'b0, sr_hr_q}, 6'd23));
        default: ;
      endcase
    end
  end

  // Photoperiod: minutes elapsed since sunrise modulo one day, computed from
  // the registered time so lights_on trails a step by one cycle.
  logic [10:0]        now_min, sr_min_of_day;
  logic signed [11:0] diff;
  logic [11:0]        diff_mod;

  always_comb begin
    now_min       = 11'(hr_q) * 11'd60 + 11'(min_q);
    sr_min_of_day = 11'(sr_hr_q) * 11'd60 + 11'(sr_min_q);
    diff          = $signed({1'b0, now_min}) - $signed({1'b0, sr_min_of_day});
    diff_mod      = (diff < 0) ? 12'(diff + 12'sd1440) : 12'(diff);
    lights_d      = (diff_mod < 12'(LIGHT_MINUTES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      hr_q        <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      sr_hr_q     <= 5'd6;
      sr_min_q    <= '0;
      lights_q    <= 1'b0;
      time_code_q <= '0;
      sr_code_q   <= '0;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sr_hr_q     <= sr_hr_d;
      sr_min_q    <= sr_min_d;
      lights_q    <= lights_d;
      time_code_q <= time_adjust;
      sr_code_q   <= sunrise_time_adjust;
    end
  end

  assign hours           = hr_q;
  assign minutes         = min_q;
  assign seconds         = sec_q;
  assign sunrise_hours   = sr_hr_q;
  assign sunrise_minutes = sr_min_q;
  assign lights_on       = lights_q;
  assign sec_tick        = tick_q;

endmodule
